ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction fetch stage for the multi-cycle RISC-V core. Owns the program counter and issues word reads to instruction memory over a req/ready handshake. Holds the fetched instruction stable for the decode/register-file stage until the instruction retires. Computes the next PC from the sequential, branch, JAL and JALR cases using the decode stage's `doBranch` and `imm32` results.

## Interface
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset; must be word-aligned.
- NOP, 32'h0000_0013, instruction word presented on `inst` while no valid instruction is held (addi x0,x0,0).

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  32  byte address of the read; always equals `pc`.
- imem_rdata  in  32  read data; sampled only on an edge where `imem_req && imem_ready`.
- imem_ready  in  1  memory completes the read this cycle; ignored while `imem_req=0`.
- inst  out  32  held instruction, driven to the decode stage.
- inst_valid  out  1  `inst` holds a real fetched instruction.
- pc  out  32  address of `inst` / current fetch address.
- pc_plus4  out  32  `pc+4`, combinational; link value for JAL/JALR.
- retire  out  1  combinational; high in the cycle the held instruction commits (`state==VALID && !stall`). Downstream gates `regWrite` with it.
- stall  in  1  downstream needs more cycles; freezes the held instruction.
- doBranch  in  1  conditional branch in `inst` is taken (from decode).
- imm32  in  32  decoded immediate for `inst` (from decode).
- rs1Data  in  32  rs1 value for `inst` (from decode).
- misaligned  out  1  sticky; set when a computed next PC has `[1:0]!=0`.

## Operation
- States: IDLE, REQ, VALID, HALT.
- Reset: state IDLE; `pc=RESET_PC`; `inst=NOP`; `inst_valid=0`; `imem_req=0`; `misaligned=0`. Reset overrides every other input in any state, including mid-request.
- IDLE: no request. Moves to REQ on the next edge.
- REQ: `imem_req=1`; `imem_addr=pc`, stable for the whole request. Waits an unbounded number of cycles for `imem_ready`.
  - On an edge with `imem_ready=1`: `inst<=imem_rdata`, `inst_valid<=1`, go to VALID.
  - `stall`, `doBranch`, `imm32` and `rs1Data` are ignored in REQ.
- VALID: `imem_req=0`; `inst`/`pc` held.
  - `stall=1`: remain in VALID; nothing changes.
  - `stall=0`: the instruction retires. `pc<=next_pc`, `inst<=NOP`, `inst_valid<=0`.
  - Then, if `next_pc[1:0]!=0`: `misaligned<=1` and go to HALT. Otherwise go to REQ.
- next_pc, selected on `inst[6:0]`; all additions 32-bit modulo 2^32, so wrap-around is silent:
  - 1101111 (JAL): `pc+imm32`.
  - 1100111 (JALR): `(rs1Data + sext(inst[31:20])) & ~1`. The immediate is extracted internally because decode returns `imm32=0` for this opcode.
  - 1100011 with `doBranch=1`: `pc+imm32`.
  - Everything else, including a not-taken branch: `pc+4`.
- HALT: no requests; `inst=NOP`, `inst_valid=0`, `retire=0`. `pc` holds the faulting target. Exit only by reset.

## Timing
- Zero-wait memory (`imem_ready=1` in the first REQ cycle):
  - cycle n: REQ;
  - cycle n+1: VALID with `inst` valid;
  - cycle n+2: REQ for the next PC.
  - Throughput is 2 cycles/instruction; each stall cycle and each memory wait cycle adds 1.
- `retire` and `stall` are evaluated in the same cycle. Register writeback occurs on the retire edge, concurrent with the `pc` update.
- First request is issued in the second cycle after `rst` deasserts (IDLE occupies the first).
- Outputs `pc`, `inst`, `inst_valid`, `imem_req`, `misaligned` are registered or decoded purely from state.

## Test plan
- Reset then zero-wait memory returning 0x00500093 at 0x0: `imem_req` high in cycle 2 after reset release with `imem_addr=0`; `inst=0x00500093` and `inst_valid=1` in cycle 3; next request at `imem_addr=0x4`.
- Memory holds `imem_ready=0` for 3 REQ cycles: `imem_addr` is constant and `inst_valid=0` throughout; `inst` captures on the 4th cycle.
- BEQ at `pc=0x10`, `doBranch=1`, `imm32=0xFFFFFFF8`: next `imem_addr=0x08`. Same case with `doBranch=0`: next `imem_addr=0x14`.
- JALR 0x003080E7 (rs1=x1, imm=3) with `rs1Data=0x100`: next `pc=0x102` (LSB cleared). `pc_plus4` equals the old `pc+4` during the retire cycle.
- JAL with `imm32=0x2` at `pc=0x20`: `misaligned=1`, state HALT, `pc=0x22`, no further `imem_req` until reset.
- `stall=1` for 5 cycles in VALID: `inst`/`pc` unchanged and `retire=0`. Reset asserted mid-REQ: `pc=RESET_PC`, `imem_req=0` on the next edge.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ready
// handshake, holds the instruction until it retires.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        retire,
  input  logic        stall,
  input  logic        doBranch,
  input  logic [31:0] imm32,
  input  logic [31:0] rs1Data,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    VALID,
    HALT
  } state_t;

  state_t      state, state_d;
  logic [31:0] pc_d;
  logic [31:0] inst_d;
  logic        mis_d;
  logic [31:0] next_pc;
  logic [31:0] jalr_imm;
  logic        is_jal, is_jalr, is_br;

  assign imem_req   = (state == REQ);
  assign imem_addr  = pc;
  assign inst_valid = (state == VALID);
  assign retire     = (state == VALID) && !stall;
  assign pc_plus4   = pc + 32'd4;

  assign is_jal   = (inst[6:0] == 7'b1101111);
  assign is_jalr  = (inst[6:0] == 7'b1100111);
  assign is_br    = (inst[6:0] == 7'b1100011);
  // decode hands back imm32=0 for JALR, so pull the I-immediate here
  assign jalr_imm = {{20{inst[31]}}, inst[31:20]};

  always_comb begin
    next_pc = pc_plus4;
    unique case (1'b1)
      is_jal:             next_pc = pc + imm32;
      is_jalr:            next_pc = (rs1Data + jalr_imm) & ~32'd1;
      (is_br && doBranch): next_pc = pc + imm32;
      default:            next_pc = pc_plus4;
    endcase
  end

  always_comb begin
    state_d = state;
    pc_d    = pc;
    inst_d  = inst;
    mis_d   = misaligned;
    unique case (state)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_ready) begin
          inst_d  = imem_rdata;
          state_d = VALID;
        end
      end
      VALID: begin
        if (!stall) begin
          pc_d   = next_pc;
          inst_d = NOP;
          if (next_pc[1:0] != 2'b00) begin
            mis_d   = 1'b1;
            state_d = HALT;
          end else begin
            state_d = REQ;
          end
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      inst       <= NOP;
      misaligned <= 1'b0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      inst       <= inst_d;
      misaligned <= mis_d;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a fetch-address and
// instruction scoreboard.
module tb_ifetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_ready = 1'b0;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        retire;
  logic        stall = 1'b0;
  logic        doBranch = 1'b0;
  logic [31:0] imm32 = '0;
  logic [31:0] rs1Data = '0;
  logic        misaligned;

  int checks = 0;
  int failures = 0;

  logic [31:0] addr_q[$];
  logic [31:0] inst_q[$];

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .inst       (inst),
    .inst_valid (inst_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .retire     (retire),
    .stall      (stall),
    .doBranch   (doBranch),
    .imm32      (imm32),
    .rs1Data    (rs1Data),
    .misaligned (misaligned)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    imem_ready = 1'b0;
    stall = 1'b0;
    step();
    step();
    addr_q.delete();
    inst_q.delete();
    rst = 1'b1;
    #1;
    check("idle_no_req", {31'b0, imem_req}, 32'd0);
    step();
    addr_q.push_back(32'h0);
  endtask

  task automatic fetch(input logic [31:0] data, input int waits);
    logic [31:0] a;
    check("req_high", {31'b0, imem_req}, 32'd1);
    if (addr_q.size() == 0) begin
      failures++;
      $error("FAIL addr_q_empty observed=0 expected=1");
      a = 'x;
    end else begin
      a = addr_q.pop_front();
    end
    check("req_addr", imem_addr, a);
    for (int i = 0; i < waits; i++) begin
      imem_ready = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      step();
      check("wait_addr", imem_addr, a);
      check("wait_nvalid", {31'b0, inst_valid}, 32'd0);
    end
    imem_ready = 1'b1;
    imem_rdata = data;
    inst_q.push_back(data);
    step();
    imem_ready = 1'b0;
    check("valid", {31'b0, inst_valid}, 32'd1);
    check("inst", inst, inst_q.pop_front());
  endtask

  task automatic retire_to(input logic br, input logic [31:0] imm,
                           input logic [31:0] rs1,
                           input logic [31:0] exp_next,
                           input logic [31:0] exp_p4);
    doBranch = br;
    imm32 = imm;
    rs1Data = rs1;
    stall = 1'b0;
    #1;
    check("retire", {31'b0, retire}, 32'd1);
    check("pc_plus4", pc_plus4, exp_p4);
    step();
    doBranch = 1'b0;
    imm32 = '0;
    rs1Data = '0;
    check("next_pc", pc, exp_next);
    check("after_nvalid", {31'b0, inst_valid}, 32'd0);
    if (exp_next[1:0] != 2'b00) begin
      check("mis_set", {31'b0, misaligned}, 32'd1);
      check("halt_noreq", {31'b0, imem_req}, 32'd0);
    end else begin
      check("next_req", {31'b0, imem_req}, 32'd1);
      addr_q.push_back(exp_next);
    end
  endtask

  initial begin
    rst = 1'b0;
    step();
    step();
    check("rst_pc", pc, 32'h0);
    check("rst_inst", inst, NOP);
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_mis", {31'b0, misaligned}, 32'd0);

    do_reset();
    fetch(32'h0050_0093, 0);
    retire_to(1'b0, 32'h0, 32'h0, 32'h4, 32'h4);
    fetch(32'h0010_0113, 3);
    retire_to(1'b0, 32'h0, 32'h0, 32'h8, 32'h8);
    fetch(NOP, 0);
    retire_to(1'b0, 32'h0, 32'h0, 32'hC, 32'hC);
    fetch(32'h0020_0193, 1);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_noret", {31'b0, retire}, 32'd0);
      step();
      check("stall_inst", inst, 32'h0020_0193);
      check("stall_pc", pc, 32'hC);
      check("stall_valid", {31'b0, inst_valid}, 32'd1);
    end
    retire_to(1'b0, 32'h0, 32'h0, 32'h10, 32'h10);
    fetch(32'hFE00_0CE3, 0);
    retire_to(1'b1, 32'hFFFF_FFF8, 32'h0, 32'h8, 32'h14);
    fetch(NOP, 0);
    retire_to(1'b0, 32'h0, 32'h0, 32'hC, 32'hC);
    fetch(NOP, 0);
    retire_to(1'b0, 32'h0, 32'h0, 32'h10, 32'h10);
    fetch(32'hFE00_0CE3, 2);
    retire_to(1'b0, 32'hFFFF_FFF8, 32'h0, 32'h14, 32'h14);
    fetch(32'h0030_80E7, 0);
    retire_to(1'b0, 32'h0, 32'h100, 32'h102, 32'h18);

    do_reset();
    fetch(32'h0200_006F, 0);
    retire_to(1'b0, 32'h20, 32'h0, 32'h20, 32'h4);
    fetch(32'h0020_006F, 0);
    retire_to(1'b0, 32'h2, 32'h0, 32'h22, 32'h24);
    imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("halt_req", {31'b0, imem_req}, 32'd0);
      check("halt_pc", pc, 32'h22);
      check("halt_inst", inst, NOP);
      check("halt_nret", {31'b0, retire}, 32'd0);
      check("halt_mis", {31'b0, misaligned}, 32'd1);
    end
    imem_ready = 1'b0;

    do_reset();
    check("rst_mis_clr", {31'b0, misaligned}, 32'd0);
    fetch(NOP, 0);
    retire_to(1'b0, 32'h0, 32'h0, 32'h4, 32'h4);
    step();
    check("midreq_req", {31'b0, imem_req}, 32'd1);
    rst = 1'b0;
    step();
    check("midrst_pc", pc, 32'h0);
    check("midrst_req", {31'b0, imem_req}, 32'd0);
    rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
